secded_encoder_tx: RTL and testbench
====================================

Name: secded_encoder_tx

Overview:
- Upstream companion to the 13-bit SECDED decoder.
- Accepts 8-bit data bytes over a valid/ready handshake and encodes each into a 13-bit extended-Hamming codeword.
- Buffers codewords in a small FIFO and presents them to the decoder-side channel over a valid/ready handshake.
- Provides one-shot error injection (XOR mask) so benches can exercise the decoder's 1-bit and 2-bit error paths, plus a count of codewords sent.

Parameters:
- DEPTH, 2, number of codeword entries in the output FIFO; power of 2, ≥2.
- CNT_W, 16, width of the sent-codeword counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a data byte.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  8  data byte to encode.
- out_valid  output  1  out_code holds a valid codeword.
- out_ready  input  1  downstream accepts out_code this cycle.
- out_code  output  13  codeword at FIFO head.
- inj_arm  input  1  single-cycle pulse: arm injection with inj_mask.
- inj_mask  input  13  XOR mask applied to the next accepted codeword.
- inj_pending  output  1  injection armed, not yet consumed.
- sent_count  output  CNT_W  number of output handshakes, modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values:
  - out_valid=0, in_ready=1, inj_pending=0, sent_count=0.
  - FIFO emptied; stored injection mask cleared to 0.
  - out_code is don't-care while out_valid=0; the RTL drives 0 after reset.
  - Reset mid-transfer discards all buffered words and any pending injection.
- Codeword layout (even overall parity):
  - Data: d[0]→bit3, d[1]→bit5, d[2]→bit6, d[3]→bit7, d[4]→bit9, d[5]→bit10, d[6]→bit11, d[7]→bit12.
  - bit1 = ^{b3,b5,b7,b9,b11}
  - bit2 = ^{b3,b6,b7,b10,b11}
  - bit4 = ^{b5,b6,b7,b12}
  - bit8 = ^{b9,b10,b11,b12}
  - bit0 = ^{b12..b1}, so the XOR of all 13 bits = 0.
  - A clean codeword yields decoder syndrome 0 with no parity failure.
- Encoding is combinational on in_data. The stored word is encoded_word XOR applied_mask.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !full; it depends only on FIFO occupancy.
  - When full, no accept that cycle even if a pop occurs in the same cycle (no pass-through).
- Output handshake:
  - Pop when out_valid && out_ready.
  - out_valid = !empty; out_code = FIFO head, stable while out_valid && !out_ready.
- Latency: a byte accepted in cycle t appears on out_code with out_valid=1 in cycle t+1 if the FIFO was empty.
- Throughput: one word per cycle while not full.
- Ordering: strict FIFO order.
- Simultaneous push and pop when not full: occupancy unchanged; both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- Error injection:
  - Arming: inj_arm=1 latches inj_mask and sets inj_pending=1 next cycle.
  - Re-arming while pending overwrites the stored mask.
  - Consumption: on the first input accept with the injection armed, the stored mask XORs into that word; inj_pending clears next cycle.
  - Arm and accept in the same cycle: the mask is applied to that same word; inj_pending stays 0.
  - When nothing is armed, the applied mask is 0.
  - A mask of 0 is legal; it consumes the arm with no corruption.
- sent_count: increments by 1 on each output handshake and wraps from 2^CNT_W−1 to 0.

Test Plan:
- Reset, then in_data=8'h00 accepted, out_ready=1 → next cycle out_valid=1, out_code=13'h0000; sent_count=1 after the pop.
- in_data=8'hFF → out_code=13'h1EEE. in_data=8'h01 → out_code=13'h000F.
- inj_arm with inj_mask=13'h0020, then send 8'h01:
  - out_code=13'h002F (1-bit error, decoder syndrome 5);
  - inj_pending 1→0;
  - a following 8'h01 → 13'h000F.
- inj_mask=13'h0006 armed in the same cycle as accepting 8'h01 → out_code=13'h0009 (2-bit error: decoder reports parity OK, syndrome≠0); inj_pending never asserts.
- out_ready=0 with DEPTH=2:
  - push 8'h01 and 8'hFF → in_ready=0 after the 2nd accept;
  - out_code holds 13'h000F stable;
  - with in_valid high, raising out_ready yields 13'h000F then 13'h1EEE, in order.
- Back-to-back stream of 300 bytes with out_ready=1, CNT_W=8 → one word per cycle, no drops; sent_count wraps to 44.
- Reset asserted with 2 words buffered and injection armed → next cycle out_valid=0, in_ready=1, inj_pending=0, sent_count=0.

Source files
------------

// File: rtl/secded_encoder_tx.sv
// Byte-to-codeword SECDED encoder (13-bit extended Hamming, even overall parity)
// with an output FIFO, one-shot XOR error injection and a sent-codeword counter.
module secded_encoder_tx #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      out_code,
  input  logic             inj_arm,
  input  logic [12:0]      inj_mask,
  output logic             inj_pending,
  output logic [CNT_W-1:0] sent_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and in_ready depends only on occupancy.

  logic [12:0]      mem_q [DEPTH];
  logic [12:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [12:0]      inj_mask_q, inj_mask_d;
  logic             inj_pending_q, inj_pending_d;
  logic [CNT_W-1:0] sent_count_q, sent_count_d;

  logic [12:0] enc_body;
  logic [12:0] enc_word;
  logic [12:0] applied_mask;
  logic        push;
  logic        pop;

  // Data bits occupy the non-power-of-two positions; parity bits cover them.
  always_comb begin
    enc_body     = '0;
    enc_body[3]  = in_data[0];
    enc_body[5]  = in_data[1];
    enc_body[6]  = in_data[2];
    enc_body[7]  = in_data[3];
    enc_body[9]  = in_data[4];
    enc_body[10] = in_data[5];
    enc_body[11] = in_data[6];
    enc_body[12] = in_data[7];
    enc_body[1]  = ^{in_data[0], in_data[1], in_data[3], in_data[4], in_data[6]};
    enc_body[2]  = ^{in_data[0], in_data[2], in_data[3], in_data[5], in_data[6]};
    enc_body[4]  = ^{in_data[1], in_data[2], in_data[3], in_data[7]};
    enc_body[8]  = ^{in_data[4], in_data[5], in_data[6], in_data[7]};
  end

  assign enc_word = {enc_body[12:1], ^enc_body[12:1]};

  assign in_ready    = (occ_q != OCC_W'(DEPTH));
  assign out_valid   = (occ_q != '0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_code    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign inj_pending = inj_pending_q;
  assign sent_count  = sent_count_q;

  // A same-cycle arm takes priority so its mask lands on the word accepted now.
  always_comb begin
    applied_mask = '0;
    if (inj_arm) begin
      applied_mask = inj_mask;
    end else if (inj_pending_q) begin
      applied_mask = inj_mask_q;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc_word ^ applied_mask;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    inj_mask_d    = inj_mask_q;
    inj_pending_d = inj_pending_q;
    if (inj_arm) begin
      inj_mask_d    = inj_mask;
      inj_pending_d = 1'b1;
    end
    if (push) begin
      inj_pending_d = 1'b0;
    end
  end

  always_comb begin
    sent_count_d = sent_count_q;
    if (pop) begin
      sent_count_d = sent_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      inj_mask_q    <= '0;
      inj_pending_q <= 1'b0;
      sent_count_q  <= '0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      inj_mask_q    <= inj_mask_d;
      inj_pending_q <= inj_pending_d;
      sent_count_q  <= sent_count_d;
    end
  end

endmodule

// File: tb/tb_secded_encoder_tx.sv
// Scoreboard bench for secded_encoder_tx: driver tasks push expected codewords,
// a negedge monitor pops and compares, plus directed and randomized phases.
module tb_secded_encoder_tx;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int W     = 13;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [12:0]      out_code;
  logic             inj_arm = 1'b0;
  logic [12:0]      inj_mask = '0;
  logic             inj_pending;
  logic [CNT_W-1:0] sent_count;

  secded_encoder_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .inj_arm    (inj_arm),
    .inj_mask   (inj_mask),
    .inj_pending(inj_pending),
    .sent_count (sent_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         armed = 1'b0;
  logic [12:0]  arm_mask = '0;
  int           rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: data fills non-power-of-two positions in order; parity at 2^k
  // covers every position with bit k set; bit0 makes the whole word even.
  function automatic logic [12:0] ref_encode(input logic [7:0] d);
    logic [12:0] w;
    logic        b;
    int          k;
    w = '0;
    k = 0;
    for (int pos = 1; pos < 13; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 13; p = p * 2) begin
      b = 1'b0;
      for (int pos = 1; pos < 13; pos++) begin
        if (((pos & p) != 0) && (pos != p)) b = b ^ w[pos];
      end
      w[p] = b;
    end
    b = 1'b0;
    for (int pos = 1; pos < 13; pos++) b = b ^ w[pos];
    w[0] = b;
    return w;
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [7:0] d, input logic use_lit, input logic [12:0] lit);
    logic [12:0] m;
    bit          done;
    int          budget;
    done     = 1'b0;
    budget   = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        m     = inj_arm ? inj_mask : (armed ? arm_mask : 13'h0);
        armed = 1'b0;
        exp_q.push_back(use_lit ? lit : (ref_encode(d) ^ m));
        done  = 1'b1;
      end
      @(posedge clock);
      #1;
      budget++;
      if (!done && budget > 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    inj_arm  = 1'b0;
  endtask

  task automatic arm_only(input logic [12:0] m);
    inj_arm  = 1'b1;
    inj_mask = m;
    @(negedge clock);
    armed    = 1'b1;
    arm_mask = m;
    @(posedge clock);
    #1;
    inj_arm  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    exp_q.delete();
    armed = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || out_valid) && budget < 200) begin
      @(posedge clock);
      #1;
      budget++;
    end
    check("drain_done", {31'd0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  int               occ_m = 0;
  logic             pend_m = 1'b0;
  logic [CNT_W-1:0] cnt_m = '0;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        occ_m  = 0;
        pend_m = 1'b0;
        cnt_m  = '0;
      end else begin
        check("in_ready", {31'd0, in_ready}, {31'd0, (occ_m < DEPTH)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (occ_m > 0)});
        check("inj_pending", {31'd0, inj_pending}, {31'd0, pend_m});
        check("sent_count", {24'd0, sent_count}, {24'd0, cnt_m});
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {19'd0, out_code}, 32'hFFFF_FFFF);
          end else begin
            check("out_code", {19'd0, out_code}, {19'd0, exp_q[0]});
            if (out_ready) begin
              void'(exp_q.pop_front());
              cnt_m = cnt_m + 1'b1;
            end
          end
        end
        occ_m = occ_m + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        if (in_valid && in_ready) pend_m = 1'b0;
        else if (inj_arm)         pend_m = 1'b1;
      end
    end
  end

  // ---------------- main sequence ----------------
  time t0;
  time t1;

  initial begin
    rdy_mode = 0;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_code", {19'd0, out_code}, 32'd0);
    @(posedge clock);
    #1;

    // Basic encodes with spec-given codewords
    send(8'h00, 1'b1, 13'h0000);
    send(8'hFF, 1'b1, 13'h1EEE);
    send(8'h01, 1'b1, 13'h000F);
    drain();
    check("count_after_3", {24'd0, sent_count}, 32'd3);

    // One-shot 1-bit injection, then a clean word
    arm_only(13'h0020);
    idle(2);
    send(8'h01, 1'b1, 13'h002F);
    send(8'h01, 1'b1, 13'h000F);
    drain();

    // Arm in the same cycle as the accept: 2-bit error, pending never set
    inj_arm  = 1'b1;
    inj_mask = 13'h0006;
    send(8'h01, 1'b1, 13'h0009);
    drain();

    // Backpressure: fill the FIFO, hold, then release with a third byte waiting
    rdy_mode = 1;
    idle(1);
    send(8'h01, 1'b1, 13'h000F);
    send(8'hFF, 1'b1, 13'h1EEE);
    @(negedge clock);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    fork
      send(8'h5A, 1'b0, 13'h0);
      begin
        repeat (3) @(negedge clock);
        rdy_mode = 0;
      end
    join
    drain();

    // Reset with words buffered and an injection armed
    rdy_mode = 1;
    idle(1);
    send(8'h33, 1'b0, 13'h0);
    send(8'hC4, 1'b0, 13'h0);
    arm_only(13'h0101);
    do_reset();
    @(negedge clock);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_inj_pending", {31'd0, inj_pending}, 32'd0);
    check("rst_sent_count", {24'd0, sent_count}, 32'd0);
    @(posedge clock);
    #1;

    // 300-byte back-to-back stream: one per cycle, counter wraps to 44
    rdy_mode = 0;
    idle(1);
    t0 = $time;
    for (int i = 0; i < 300; i++) send(8'($urandom), 1'b0, 13'h0);
    t1 = $time;
    check("stream_cycles", 32'((t1 - t0) / 10), 32'd300);
    drain();
    check("stream_count_wrap", {24'd0, sent_count}, 32'd44);

    // Randomized traffic with random backpressure and injections
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        0: arm_only(13'($urandom));
        1: begin
          inj_arm  = 1'b1;
          inj_mask = 13'(1 << $urandom_range(0, 12));
          send(8'($urandom), 1'b0, 13'h0);
        end
        2: idle($urandom_range(1, 3));
        default: send(8'($urandom), 1'b0, 13'h0);
      endcase
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
